// File: rtl/intr_pkg.sv
// Shared types and constants for the interrupt controller.
package intr_pkg;

  // Upper bound on external sources and the width of the cause index.
  localparam int unsigned MaxIrq = 8;
  localparam int unsigned CauseW = 3;

  // Controller sequencing states.
  typedef enum logic [1:0] {
    StIdle,
    StTake,
    StIsr,
    StRet
  } intr_state_e;

  // Index of the lowest set bit; 0 when no bit is set.
  function automatic logic [CauseW-1:0] lowest_idx(input logic [MaxIrq-1:0] vec);
    logic [CauseW-1:0] idx;
    idx = '0;
    for (int i = MaxIrq - 1; i >= 0; i--) begin
      if (vec[i]) idx = CauseW'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/irq_sync.sv
// Per-source synchronizer chain followed by rising-edge detection.
module irq_sync #(
  parameter int unsigned Stages = 2
) (
  input  logic CLK,
  input  logic RST,
  input  logic irq_i,
  input  logic arm_i,
  output logic rise_o
);

  logic [Stages-1:0] sync_q;
  logic              prev_q;

  // Shift the asynchronous level in; keep one cycle of history for the edge detect.
  always_ff @(posedge CLK) begin
    if (RST) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[Stages-2:0], irq_i};
      prev_q <= sync_q[Stages-1];
    end
  end

  // Edges are only reported once both the chain and the history hold post-reset samples,
  // so a level held high through reset does not look like a new edge.
  always_comb begin
    rise_o = arm_i & sync_q[Stages-1] & ~prev_q;
  end

endmodule

// File: rtl/intr_ctrl.sv
// Machine-level interrupt controller: pending/mask registers, fixed priority, and the
// entry/return sequencer that redirects the core PC.
// Optional build macro INTR_AUTOCLR_EN: clear the winning pending bit in the entry cycle.
module intr_ctrl #(
  parameter int unsigned NUM_IRQ     = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [NUM_IRQ-1:0]  IRQ_IN,
  input  logic                CSR_MSTATUS_MIE,
  input  logic [31:0]         CSR_MTVEC,
  input  logic [31:0]         CSR_MEPC,
  input  logic                INSTR_DONE,
  input  logic                MRET_DECODED,
  input  logic [31:0]         PC_NEXT,
  input  logic                MASK_WE,
  input  logic [NUM_IRQ-1:0]  MASK_WD,
  input  logic                CLR_WE,
  input  logic [NUM_IRQ-1:0]  CLR_WD,
  output logic                INT_TAKEN,
  output logic                MRET_EXEC,
  output logic [31:0]         INT_PC,
  output logic                PC_REDIRECT,
  output logic [31:0]         PC_TARGET,
  output logic [NUM_IRQ-1:0]  IRQ_PENDING,
  output logic [2:0]          IRQ_CAUSE
);

  import intr_pkg::*;

  // Post-reset warm-up: edge detect is held off until sync chain and history are refilled.
  localparam int unsigned ArmW   = $clog2(SYNC_STAGES + 2);
  localparam int unsigned ArmMax = SYNC_STAGES + 1;

  intr_state_e       state_q, state_d;
  logic [NUM_IRQ-1:0] pending_q, pending_d;
  logic [NUM_IRQ-1:0] mask_q, mask_d;
  logic [31:0]        int_pc_q, int_pc_d;
  logic [CauseW-1:0]  cause_q, cause_d;
  logic [ArmW-1:0]    arm_cnt_q, arm_cnt_d;
  logic               armed;
  logic [NUM_IRQ-1:0] rise;
  logic [NUM_IRQ-1:0] eligible;
  logic [MaxIrq-1:0]  eligible_ext;
  logic [NUM_IRQ-1:0] clr_mask;
  logic               take_ev;

  for (genvar g = 0; g < NUM_IRQ; g++) begin : g_sync
    irq_sync #(
      .Stages(SYNC_STAGES)
    ) u_irq_sync (
      .CLK   (CLK),
      .RST   (RST),
      .irq_i (IRQ_IN[g]),
      .arm_i (armed),
      .rise_o(rise[g])
    );
  end

  // Warm-up counter saturates once edge detection is trustworthy.
  always_comb begin
    armed     = (arm_cnt_q == ArmW'(ArmMax));
    arm_cnt_d = armed ? arm_cnt_q : arm_cnt_q + 1'b1;
  end

  // Eligibility and pending/mask next state; a new edge beats a same-cycle clear.
  always_comb begin
    eligible                   = pending_q & mask_q;
    eligible_ext               = '0;
    eligible_ext[NUM_IRQ-1:0]  = eligible;
    clr_mask                   = CLR_WE ? CLR_WD : '0;
`ifdef INTR_AUTOCLR_EN
    if (state_q == StTake) begin
      for (int i = 0; i < NUM_IRQ; i++) begin
        if (cause_q == CauseW'(i)) clr_mask[i] = 1'b1;
      end
    end
`endif
    pending_d = (pending_q & ~clr_mask) | rise;
    mask_d    = MASK_WE ? MASK_WD : mask_q;
  end

  // Sequencer next state; mret wins over an interrupt at the same boundary.
  always_comb begin
    state_d = state_q;
    take_ev = 1'b0;
    case (state_q)
      StIdle: begin
        if (INSTR_DONE && MRET_DECODED) begin
          state_d = StRet;
        end else if (INSTR_DONE && CSR_MSTATUS_MIE && (|eligible)) begin
          state_d = StTake;
          take_ev = 1'b1;
        end
      end
      StTake:  state_d = StIsr;
      StIsr:   if (INSTR_DONE && MRET_DECODED) state_d = StRet;
      StRet:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
    int_pc_d = take_ev ? PC_NEXT : int_pc_q;
    cause_d  = take_ev ? lowest_idx(eligible_ext) : cause_q;
  end

  // Redirect/strobe outputs decoded from the current state.
  always_comb begin
    INT_TAKEN   = 1'b0;
    MRET_EXEC   = 1'b0;
    PC_REDIRECT = 1'b0;
    PC_TARGET   = '0;
    case (state_q)
      StTake: begin
        INT_TAKEN   = 1'b1;
        PC_REDIRECT = 1'b1;
        PC_TARGET   = CSR_MTVEC;
      end
      StRet: begin
        MRET_EXEC   = 1'b1;
        PC_REDIRECT = 1'b1;
        PC_TARGET   = CSR_MEPC;
      end
      default: ;
    endcase
  end

  // State registers; reset aborts any sequence in flight.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= StIdle;
      pending_q <= '0;
      mask_q    <= '0;
      int_pc_q  <= '0;
      cause_q   <= '0;
      arm_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      mask_q    <= mask_d;
      int_pc_q  <= int_pc_d;
      cause_q   <= cause_d;
      arm_cnt_q <= arm_cnt_d;
    end
  end

  assign INT_PC      = int_pc_q;
  assign IRQ_PENDING = pending_q;
  assign IRQ_CAUSE   = cause_q;

endmodule
